instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the five-stage RISC-V pipeline: owns the PC, issues a request/acknowledge transaction to the instruction memory/cache, and drives the IF/ID pipeline register that the decode stage (control, register file, immediate sign-extension) consumes. It absorbs variable memory latency, holds on load-use stalls, and redirects on taken branches, discarding any in-flight or buffered wrong-path fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC of first fetch after reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) loaded into IF/ID on flush or fetch gap

- clk_i  in  1  single clock; all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address; stable while imem_req_o=1 until ack
- imem_ack_i  in  1  one-cycle response strobe; completes current request (may arrive same cycle as request)
- imem_data_i  in  32  instruction word, valid when imem_ack_i=1
- stall_i  in  1  hazard-unit stall: hold IF/ID and PC
- flush_i  in  1  taken branch in ID: squash IF/ID, redirect PC
- branch_target_i  in  32  redirect PC, sampled when flush_i=1
- pc_o  out  32  IF/ID PC
- instr_o  out  32  IF/ID instruction
- valid_o  out  1  IF/ID holds a real instruction

## Operation
- Registers: pc_q (next PC to fetch), addr_q (address of outstanding request), buf_q (skid buffer), state, IF/ID {pc, instr, valid}.
- States: IDLE, REQ, HOLD, DRAIN. Priority everywhere: flush_i > stall_i > normal.
- IDLE: req=0; next cycle -> REQ, addr_q=pc_q.
- REQ: req=1, imem_addr_o=addr_q.
  - ack & flush: discard data; pc_q,addr_q <= branch_target_i; stay REQ.
  - ack & stall: buf_q <= data; -> HOLD; IF/ID held.
  - ack otherwise: IF/ID <= {addr_q, data, 1}; pc_q,addr_q <= addr_q+4; stay REQ (new transaction next cycle).
  - no ack & flush: pc_q <= target; -> DRAIN (addr_q kept).
  - no ack, no flush: stay REQ; IF/ID held if stall_i, else loaded with bubble.
- HOLD: req=0. flush: discard buf_q, pc_q,addr_q <= target, -> REQ. stall: hold. Else IF/ID <= {addr_q, buf_q, 1}, pc_q,addr_q <= addr_q+4, -> REQ.
- DRAIN: req=1 on old addr_q; flush updates pc_q to newest target. On ack: discard data, addr_q <= pc_q, -> REQ.
- Any flush_i cycle loads IF/ID bubble {pc_o unchanged, NOP_INSTR, 0}, regardless of stall_i.
- PC arithmetic: 32-bit, +4 wraps modulo 2^32; branch_target_i used unmodified.

## Timing
- Reset (async): state=IDLE, pc_q=addr_q=RESET_PC, buf_q=0, imem_req_o=0, imem_addr_o=RESET_PC, pc_o=0, instr_o=NOP_INSTR, valid_o=0.
- After release: edge 1 -> REQ; zero-wait memory acks same cycle; edge 2 presents RESET_PC instruction with valid_o=1.
- Latency: ack at cycle n -> instr_o valid after edge n+1. Zero-wait throughput: 1 instr/cycle.
- Stall of k cycles: IF/ID and imem_addr_o unchanged k cycles; at most one fetched word buffered; no request issued while HOLD.
- Flush with request outstanding: exactly one wrong-path ack is dropped; first target fetch is issued the cycle after that ack.
- Reset mid-transaction: request abandoned immediately; memory is reset by the same rst_i.

## Structure
- Shared package cpu_pkg: NOP_INSTR constant, RESET_PC default, fetch-state enum (IDLE/REQ/HOLD/DRAIN), 32-bit word typedef.
- One sub-module: if_id_reg (pc/instr/valid register with load, hold, bubble controls); FSM and PC logic in instr_fetch.

## Test plan
- Zero-wait memory, no stall/flush, RESET_PC=0 -> instr_o sequence for pc_o 0x0,0x4,0x8,... one per cycle, valid_o=1 from edge 2.
- Ack latency 3 cycles -> each instruction valid 1 cycle after its ack, bubbles (NOP, valid_o=0) between, imem_addr_o stable while waiting.
- Ack at pc 0x10 with stall_i high 2 cycles -> IF/ID holds prior instr, imem_req_o=0, then 0x10 instr appears, next request 0x14.
- flush_i with target 0x100 while request to 0x20 outstanding (latency 2) -> 0x20 data never reaches instr_o; next request 0x100; IF/ID bubble on flush cycle.
- flush_i and stall_i same cycle in HOLD -> buffer discarded, valid_o=0, fetch resumes at target.
- Assert rst_i mid-DRAIN -> all outputs at reset values immediately; refetch from RESET_PC after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch stage
//
// Contents:
//   word_t            32-bit machine word
//   NOP_INSTR         bubble instruction (addi x0,x0,0)
//   RESET_PC_DEFAULT  default PC of the first fetch after reset
//   fetch_state_t     fetch FSM states (IDLE/REQ/HOLD/DRAIN)
//   pc_plus4()        sequential PC increment, wraps modulo 2^32

package cpu_pkg;

    typedef logic [31:0] word_t;

    localparam word_t NOP_INSTR        = 32'h0000_0013;
    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    // Plain 32-bit add: a carry out of bit 31 is dropped, so the PC wraps.
    function automatic word_t pc_plus4(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and bubble controls
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   load_i             capture {pc_i, instr_i} as a valid instruction
//   bubble_i           replace the instruction with NOP_INSTR, clear valid,
//                      keep pc_o; takes priority over load_i
//   pc_i, instr_i      incoming fetch result
//   pc_o, instr_o      registered PC and instruction seen by decode
//   valid_o            register holds a real instruction
// With neither load_i nor bubble_i asserted the register holds its contents.

module if_id_reg
    import cpu_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load_i,
    input  logic  bubble_i,
    input  word_t pc_i,
    input  word_t instr_i,
    output word_t pc_o,
    output word_t instr_o,
    output logic  valid_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_o    <= '0;
            instr_o <= NOP_INSTR;
            valid_o <= 1'b0;
        end else if (bubble_i) begin
            // pc_o is left alone so decode still sees the last real PC.
            instr_o <= NOP_INSTR;
            valid_o <= 1'b0;
        end else if (load_i) begin
            pc_o    <= pc_i;
            instr_o <= instr_i;
            valid_o <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RISC-V instruction fetch stage with IF/ID register
//
// Parameters:
//   RESET_PC          PC of the first fetch after reset
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   imem_req_o        fetch request valid (registered)
//   imem_addr_o       fetch address, stable from request until ack
//   imem_ack_i        one-cycle completion strobe, may coincide with request
//   imem_data_i       instruction word, valid with imem_ack_i
//   stall_i           hold IF/ID and the PC
//   flush_i           squash IF/ID and redirect to branch_target_i
//   branch_target_i   redirect address, sampled with flush_i
//   pc_o, instr_o     IF/ID PC and instruction
//   valid_o           IF/ID holds a real instruction
// Priority in every state: flush_i over stall_i over normal flow.

module instr_fetch
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic  clk_i,
    input  logic  rst_i,
    output logic  imem_req_o,
    output word_t imem_addr_o,
    input  logic  imem_ack_i,
    input  word_t imem_data_i,
    input  logic  stall_i,
    input  logic  flush_i,
    input  word_t branch_target_i,
    output word_t pc_o,
    output word_t instr_o,
    output logic  valid_o
);

    fetch_state_t state_q;
    word_t        pc_q;     // next PC to fetch (absorbs redirects during DRAIN)
    word_t        addr_q;   // address of the outstanding request
    word_t        buf_q;    // skid buffer for a word acked while stalled
    logic         req_q;

    logic  if_load;
    logic  if_bubble;
    word_t if_instr;

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;

    // IF/ID control. A word is delivered either straight from memory (ack in
    // REQ) or out of the skid buffer (HOLD). Any cycle that is neither stalled
    // nor delivering is a fetch gap and inserts a bubble; flush always does.
    always_comb begin
        if_load   = 1'b0;
        if_bubble = 1'b0;
        if_instr  = imem_data_i;
        if (state_q == ST_HOLD) begin
            if_instr = buf_q;
        end
        if (!flush_i && !stall_i) begin
            if_load = ((state_q == ST_REQ) && imem_ack_i) || (state_q == ST_HOLD);
        end
        if_bubble = flush_i || (!stall_i && !if_load);
    end

    // Fetch FSM. req_q is registered together with the state so that it
    // reads 1 exactly in REQ and DRAIN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            buf_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flush_i) begin
                        pc_q   <= branch_target_i;
                        addr_q <= branch_target_i;
                    end else begin
                        addr_q <= pc_q;
                    end
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                end

                ST_REQ: begin
                    if (imem_ack_i) begin
                        if (flush_i) begin
                            // Wrong-path word is simply not captured.
                            pc_q   <= branch_target_i;
                            addr_q <= branch_target_i;
                        end else if (stall_i) begin
                            // Park the word; no new request until it drains.
                            buf_q   <= imem_data_i;
                            state_q <= ST_HOLD;
                            req_q   <= 1'b0;
                        end else begin
                            pc_q   <= pc_plus4(addr_q);
                            addr_q <= pc_plus4(addr_q);
                        end
                    end else if (flush_i) begin
                        // The old request must complete before the address
                        // may change; remember the target in pc_q meanwhile.
                        pc_q    <= branch_target_i;
                        state_q <= ST_DRAIN;
                    end
                end

                ST_HOLD: begin
                    if (flush_i) begin
                        pc_q    <= branch_target_i;
                        addr_q  <= branch_target_i;
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end else if (!stall_i) begin
                        pc_q    <= pc_plus4(addr_q);
                        addr_q  <= pc_plus4(addr_q);
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (flush_i) begin
                        pc_q <= branch_target_i;
                    end
                    if (imem_ack_i) begin
                        // A flush landing on the drain ack is the newest
                        // target and must win over the stored one.
                        addr_q  <= flush_i ? branch_target_i : pc_q;
                        state_q <= ST_REQ;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (if_load),
        .bubble_i (if_bubble),
        .pc_i     (addr_q),
        .instr_i  (if_instr),
        .pc_o     (pc_o),
        .instr_o  (instr_o),
        .valid_o  (valid_o)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch

module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Memory model: latency counted in cycles the request has been waiting.
    int fixed_lat = 0;
    bit lat_rand  = 0;
    int wcnt      = 0;
    int cur_lat   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_ack  = imem_req && (wcnt >= cur_lat);
    assign imem_data = mem_word(imem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt    <= 0;
            cur_lat <= lat_rand ? 0 : fixed_lat;
        end else if (imem_req) begin
            if (imem_ack) begin
                wcnt    <= 0;
                cur_lat <= lat_rand ? int'($urandom_range(0, 3)) : fixed_lat;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    instr_fetch dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ack_i      (imem_ack),
        .imem_data_i     (imem_data),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_target_i (branch_target),
        .pc_o            (pc),
        .instr_o         (instr),
        .valid_o         (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset(input int lat, input bit rnd);
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        branch_target = '0;
        fixed_lat = lat;
        lat_rand  = rnd;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the first negedge showing address a.
    task automatic wait_addr(input logic [31:0] a, output bit found);
        int n;
        n = 0;
        while (imem_addr !== a && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        found = (imem_addr === a);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if ({imem_req, imem_addr, pc, instr, valid} !== {1'b0, 32'h0, 32'h0, NOP, 1'b0})
            $display("FAIL reset_state: got req=%b addr=%h pc=%h instr=%h valid=%b expected 0/0/0/%h/0",
                     imem_req, imem_addr, pc, instr, valid, NOP);
        else pass_cnt++;
    endtask

    task automatic test_zero_wait();
        do_reset(0, 1'b0);
        @(posedge clk); #1;
        total_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0)
            $display("FAIL zw_edge1: got req=%b addr=%h valid=%b expected 1/0/0", imem_req, imem_addr, valid);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (pc !== 32'(4 * i) || instr !== mem_word(32'(4 * i)) || valid !== 1'b1)
                $display("FAIL zw_seq%0d: got pc=%h instr=%h valid=%b expected pc=%h instr=%h valid=1",
                         i, pc, instr, valid, 32'(4 * i), mem_word(32'(4 * i)));
            else pass_cnt++;
        end
    endtask

    task automatic test_latency3();
        logic [31:0] exp_pc, p_addr;
        logic p_req, p_ack;
        int deliveries;
        exp_pc = 0;
        deliveries = 0;
        do_reset(3, 1'b0);
        for (int c = 0; c < 20; c++) begin
            p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            @(posedge clk); #1;
            total_cnt++;
            if (valid !== p_ack)
                $display("FAIL lat_valid c%0d: got valid=%b expected %b", c, valid, p_ack);
            else pass_cnt++;
            if (p_ack) begin
                total_cnt++;
                if (pc !== exp_pc || instr !== mem_word(exp_pc))
                    $display("FAIL lat_data: got pc=%h instr=%h expected pc=%h instr=%h", pc, instr, exp_pc, mem_word(exp_pc));
                else pass_cnt++;
                exp_pc += 4;
                deliveries++;
            end else begin
                total_cnt++;
                if (instr !== NOP)
                    $display("FAIL lat_bubble c%0d: got instr=%h expected %h", c, instr, NOP);
                else pass_cnt++;
            end
            if (p_req && !p_ack) begin
                total_cnt++;
                if (imem_req !== 1'b1 || imem_addr !== p_addr)
                    $display("FAIL lat_addr_stable: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, p_addr);
                else pass_cnt++;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (deliveries != 4)
            $display("FAIL lat_count: got %0d deliveries expected 4", deliveries);
        else pass_cnt++;
    endtask

    task automatic test_stall_hold();
        bit found;
        do_reset(0, 1'b0);
        wait_addr(32'h10, found);
        total_cnt++;
        if (!found || imem_ack !== 1'b1)
            $display("FAIL stall_reach: got found=%b ack=%b expected 1/1", found, imem_ack);
        else pass_cnt++;
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (imem_req !== 1'b0 || imem_addr !== 32'h10 || pc !== 32'hC ||
                instr !== mem_word(32'hC) || valid !== 1'b1)
                $display("FAIL stall_hold%0d: got req=%b addr=%h pc=%h valid=%b expected 0/10/c/1",
                         k, imem_req, imem_addr, pc, valid);
            else pass_cnt++;
            @(negedge clk);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (pc !== 32'h10 || instr !== mem_word(32'h10) || valid !== 1'b1 ||
            imem_req !== 1'b1 || imem_addr !== 32'h14)
            $display("FAIL stall_release: got pc=%h instr=%h valid=%b req=%b addr=%h expected 10/%h/1/1/14",
                     pc, instr, valid, imem_req, imem_addr, mem_word(32'h10));
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_flush_outstanding();
        bit found, dropped, done;
        int n;
        do_reset(2, 1'b0);
        wait_addr(32'h20, found);
        total_cnt++;
        if (!found || imem_ack !== 1'b0)
            $display("FAIL fo_reach: got found=%b ack=%b expected 1/0", found, imem_ack);
        else pass_cnt++;
        flush = 1'b1;
        branch_target = 32'h100;
        @(posedge clk); #1;
        total_cnt++;
        if (valid !== 1'b0 || instr !== NOP || pc !== 32'h1C)
            $display("FAIL fo_bubble: got pc=%h instr=%h valid=%b expected 1c/%h/0", pc, instr, valid, NOP);
        else pass_cnt++;
        @(negedge clk);
        flush = 1'b0;
        dropped = 0; done = 0; n = 0;
        while (!done && n < 20) begin
            if (imem_req && imem_ack && !dropped) begin
                dropped = 1;
                total_cnt++;
                if (imem_addr !== 32'h20)
                    $display("FAIL fo_drop_addr: got %h expected 00000020", imem_addr);
                else pass_cnt++;
                @(posedge clk); #1;
                total_cnt++;
                if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
                    $display("FAIL fo_redirect: got valid=%b req=%b addr=%h expected 0/1/100", valid, imem_req, imem_addr);
                else pass_cnt++;
            end else begin
                @(posedge clk); #1;
                if (valid === 1'b1) begin
                    done = 1;
                    total_cnt++;
                    if (!dropped || pc !== 32'h100 || instr !== mem_word(32'h100))
                        $display("FAIL fo_first_target: got dropped=%b pc=%h instr=%h expected 1/100/%h",
                                 dropped, pc, instr, mem_word(32'h100));
                    else pass_cnt++;
                end
            end
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (!done)
            $display("FAIL fo_timeout: got no target delivery expected one within 20 cycles");
        else pass_cnt++;
    endtask

    task automatic test_flush_stall_hold();
        bit found;
        do_reset(0, 1'b0);
        wait_addr(32'h8, found);
        stall = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (!found || imem_req !== 1'b0)
            $display("FAIL fsh_enter_hold: got found=%b req=%b expected 1/0", found, imem_req);
        else pass_cnt++;
        @(negedge clk);
        flush = 1'b1;
        branch_target = 32'h200;
        @(posedge clk); #1;
        total_cnt++;
        if (valid !== 1'b0 || instr !== NOP || pc !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h200)
            $display("FAIL fsh_flush: got pc=%h instr=%h valid=%b req=%b addr=%h expected 4/%h/0/1/200",
                     pc, instr, valid, imem_req, imem_addr, NOP);
        else pass_cnt++;
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (pc !== 32'h200 || instr !== mem_word(32'h200) || valid !== 1'b1)
            $display("FAIL fsh_resume: got pc=%h instr=%h valid=%b expected 200/%h/1", pc, instr, valid, mem_word(32'h200));
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain();
        bit found, done;
        int n;
        do_reset(3, 1'b0);
        wait_addr(32'h8, found);
        flush = 1'b1;
        branch_target = 32'h300;
        @(posedge clk); #1;
        total_cnt++;
        if (!found || imem_req !== 1'b1 || imem_addr !== 32'h8 || valid !== 1'b0)
            $display("FAIL rmd_drain: got found=%b req=%b addr=%h valid=%b expected 1/1/8/0", found, imem_req, imem_addr, valid);
        else pass_cnt++;
        @(negedge clk);
        flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({imem_req, imem_addr, pc, instr, valid} !== {1'b0, 32'h0, 32'h0, NOP, 1'b0})
            $display("FAIL rmd_async_reset: got req=%b addr=%h pc=%h instr=%h valid=%b expected 0/0/0/%h/0",
                     imem_req, imem_addr, pc, instr, valid, NOP);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL rmd_refetch_req: got req=%b addr=%h expected 1/0", imem_req, imem_addr);
        else pass_cnt++;
        done = 0; n = 0;
        while (!done && n < 30) begin
            @(posedge clk); #1;
            if (valid === 1'b1) done = 1;
            n++;
        end
        total_cnt++;
        if (!done || pc !== 32'h0 || instr !== mem_word(32'h0))
            $display("FAIL rmd_refetch: got done=%b pc=%h instr=%h expected 1/0/%h", done, pc, instr, mem_word(32'h0));
        else pass_cnt++;
        @(negedge clk);
    endtask

    // Instruction-stream model: delivered PCs follow +4 from the last
    // redirect target, each carrying its memory word; stalls freeze IF/ID,
    // flushes bubble it, and a waiting request keeps its address.
    task automatic test_random();
        logic [31:0] exp_pc, p_pc, p_instr, p_addr, tgt;
        logic p_valid, p_req, p_ack, s, f;
        int deliveries;
        exp_pc = 32'h0;
        deliveries = 0;
        do_reset(0, 1'b1);
        for (int c = 0; c < 800; c++) begin
            s = ($urandom_range(0, 99) < 25);
            f = ($urandom_range(0, 99) < 7);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFF8;
                1:       tgt = $urandom & 32'hFFFF_FFFC;
                default: tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            endcase
            stall = s;
            flush = f;
            branch_target = tgt;
            p_pc = pc; p_instr = instr; p_valid = valid;
            p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            @(posedge clk); #1;
            total_cnt++;
            if (f) begin
                exp_pc = tgt;
                if (valid !== 1'b0 || instr !== NOP || pc !== p_pc)
                    $display("FAIL rnd_flush c%0d: got pc=%h instr=%h valid=%b expected %h/%h/0", c, pc, instr, valid, p_pc, NOP);
                else pass_cnt++;
            end else if (s) begin
                if (pc !== p_pc || instr !== p_instr || valid !== p_valid)
                    $display("FAIL rnd_stall c%0d: got pc=%h instr=%h valid=%b expected %h/%h/%b",
                             c, pc, instr, valid, p_pc, p_instr, p_valid);
                else pass_cnt++;
            end else if (valid === 1'b1) begin
                if (pc !== exp_pc || instr !== mem_word(exp_pc))
                    $display("FAIL rnd_deliver c%0d: got pc=%h instr=%h expected %h/%h", c, pc, instr, exp_pc, mem_word(exp_pc));
                else pass_cnt++;
                exp_pc += 4;
                deliveries++;
            end else begin
                if (instr !== NOP)
                    $display("FAIL rnd_gap c%0d: got instr=%h expected %h", c, instr, NOP);
                else pass_cnt++;
            end
            if (p_req && !p_ack) begin
                total_cnt++;
                if (imem_req !== 1'b1 || imem_addr !== p_addr)
                    $display("FAIL rnd_addr_stable c%0d: got req=%b addr=%h expected 1/%h", c, imem_req, imem_addr, p_addr);
                else pass_cnt++;
            end
            @(negedge clk);
        end
        stall = 1'b0;
        flush = 1'b0;
        total_cnt++;
        if (deliveries < 100)
            $display("FAIL rnd_progress: got %0d deliveries expected at least 100", deliveries);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        branch_target = '0;
        test_reset();
        test_zero_wait();
        test_latency3();
        test_stall_hold();
        test_flush_outstanding();
        test_flush_stall_hold();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
